// File: rtl/fifo_thresholds_if.sv
// Handshake, threshold and status bundle between a FIFO user and fifo_thresholds.
// master: the user side (flow-control FSM / producer / consumer).
// slave:  the FIFO itself.
interface fifo_thresholds_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
);
  logic              th_load;
  logic [ADDR_W-1:0] af_th;
  logic [ADDR_W-1:0] ae_th;
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic              error;

  modport master (
    output th_load, af_th, ae_th, push, data_in, pop,
    input  data_out, valid_out, count, empty, full, almost_full, almost_empty, error
  );

  modport slave (
    input  th_load, af_th, ae_th, push, data_in, pop,
    output data_out, valid_out, count, empty, full, almost_full, almost_empty, error
  );
endinterface

// File: rtl/fifo_thresholds.sv
// Synchronous FIFO with run-time programmable almost-full/almost-empty
// thresholds and a sticky overflow/underflow error flag. Status flags are
// decoded from the registered count and threshold registers, so they change
// only on clock edges and always line up with count.
module fifo_thresholds #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  fifo_thresholds_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] AF_RST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] AE_RST   = ADDR_W'(1'b1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W-1:0] af_reg_r;
  logic [ADDR_W-1:0] ae_reg_r;
  logic [DATA_W-1:0] data_out_r;
  logic              valid_out_r;
  logic              error_r;

  logic              empty_s;
  logic              full_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              err_evt_s;
  logic [ADDR_W:0]   count_nxt_s;

  // Decode occupancy flags and the accepted write/read/error events for this cycle.
  always_comb begin
    empty_s   = (count_r == {(ADDR_W+1){1'b0}});
    full_s    = (count_r == DEPTH_C);
    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    wr_en_s   = bus.push && (!full_s || bus.pop);
    rd_en_s   = bus.pop && !empty_s;
    err_evt_s = (bus.push && !bus.pop && full_s) || (bus.pop && empty_s);
  end

  // Next occupancy: only a lone write or a lone read moves the count.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; contents are not cleared by reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_s) begin
      mem_r[wr_ptr_r] <= bus.data_in;
    end
  end

  // Pointers, count, read data register, thresholds and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {(ADDR_W+1){1'b0}};
      data_out_r  <= {DATA_W{1'b0}};
      valid_out_r <= 1'b0;
      error_r     <= 1'b0;
      af_reg_r    <= AF_RST;
      ae_reg_r    <= AE_RST;
    end else begin
      count_r     <= count_nxt_s;
      valid_out_r <= rd_en_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
        data_out_r <= mem_r[rd_ptr_r];
      end
      if (err_evt_s) begin
        error_r <= 1'b1;
      end
      if (bus.th_load) begin
        af_reg_r <= bus.af_th;
        ae_reg_r <= bus.ae_th;
      end
    end
  end

  // Drive the bus; flags come straight from registered state.
  assign bus.data_out     = data_out_r;
  assign bus.valid_out    = valid_out_r;
  assign bus.count        = count_r;
  assign bus.empty        = empty_s;
  assign bus.full         = full_s;
  assign bus.almost_full  = (af_reg_r != {ADDR_W{1'b0}}) && (count_r >= {1'b0, af_reg_r});
  assign bus.almost_empty = (count_r <= {1'b0, ae_reg_r});
  assign bus.error        = error_r;
endmodule

// File: tb/tb_fifo_thresholds.sv
// Directed self-checking bench for fifo_thresholds (DATA_W=6, DEPTH=4).
module tb_fifo_thresholds;
  logic clk;
  logic reset;
  int   total;
  int   passed;

  fifo_thresholds_if #(.DATA_W(6), .ADDR_W(2)) bus ();

  fifo_thresholds #(.DATA_W(6), .ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock: inputs set beforehand, outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.th_load = 1'b0;
    bus.af_th   = 2'd0;
    bus.ae_th   = 2'd0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = 6'h00;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    idle_inputs();

    // Reset then idle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
    chk("rst_af", 32'(bus.almost_full), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_dout", 32'(bus.data_out), 32'd0);

    // Fill with 1..4; default af_reg=3, ae_reg=1.
    bus.push = 1'b1;
    bus.data_in = 6'h01; step();
    chk("fill1_count", 32'(bus.count), 32'd1);
    chk("fill1_af", 32'(bus.almost_full), 32'd0);
    chk("fill1_ae", 32'(bus.almost_empty), 32'd1);
    bus.data_in = 6'h02; step();
    chk("fill2_count", 32'(bus.count), 32'd2);
    chk("fill2_ae", 32'(bus.almost_empty), 32'd0);
    chk("fill2_af", 32'(bus.almost_full), 32'd0);
    bus.data_in = 6'h03; step();
    chk("fill3_count", 32'(bus.count), 32'd3);
    chk("fill3_af", 32'(bus.almost_full), 32'd1);
    chk("fill3_full", 32'(bus.full), 32'd0);
    bus.data_in = 6'h04; step();
    chk("fill4_count", 32'(bus.count), 32'd4);
    chk("fill4_full", 32'(bus.full), 32'd1);
    chk("fill4_af", 32'(bus.almost_full), 32'd1);
    bus.push = 1'b0;

    // Drain in order.
    bus.pop = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("drain_data", 32'(bus.data_out), 32'(i));
      chk("drain_valid", 32'(bus.valid_out), 32'd1);
      chk("drain_count", 32'(bus.count), 32'(4 - i));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    bus.pop = 1'b0;
    step();
    chk("idle_valid", 32'(bus.valid_out), 32'd0);
    chk("idle_dout_hold", 32'(bus.data_out), 32'h04);
    chk("idle_error", 32'(bus.error), 32'd0);

    // Program af=2, ae=0.
    bus.th_load = 1'b1; bus.af_th = 2'd2; bus.ae_th = 2'd0;
    step();
    bus.th_load = 1'b0;
    chk("th0_ae", 32'(bus.almost_empty), 32'd1);
    chk("th0_af", 32'(bus.almost_full), 32'd0);
    bus.push = 1'b1;
    bus.data_in = 6'h0A; step();
    chk("th1_ae", 32'(bus.almost_empty), 32'd0);
    chk("th1_af", 32'(bus.almost_full), 32'd0);
    bus.data_in = 6'h0B; step();
    chk("th2_af", 32'(bus.almost_full), 32'd1);
    // Disable almost_full while pushing.
    bus.th_load = 1'b1; bus.af_th = 2'd0; bus.ae_th = 2'd0;
    bus.data_in = 6'h0C; step();
    bus.th_load = 1'b0;
    chk("th3_count", 32'(bus.count), 32'd3);
    chk("th3_af_off", 32'(bus.almost_full), 32'd0);
    bus.data_in = 6'h0D; step();
    chk("th4_full", 32'(bus.full), 32'd1);
    chk("th4_af_off", 32'(bus.almost_full), 32'd0);

    // Simultaneous push+pop while full.
    bus.pop = 1'b1;
    bus.data_in = 6'h11; step();
    chk("pp1_data", 32'(bus.data_out), 32'h0A);
    chk("pp1_count", 32'(bus.count), 32'd4);
    bus.data_in = 6'h12; step();
    chk("pp2_data", 32'(bus.data_out), 32'h0B);
    bus.data_in = 6'h13; step();
    chk("pp3_data", 32'(bus.data_out), 32'h0C);
    chk("pp3_count", 32'(bus.count), 32'd4);
    chk("pp3_error", 32'(bus.error), 32'd0);
    chk("pp3_valid", 32'(bus.valid_out), 32'd1);

    // Overflow: push 0x3F while full with no pop.
    bus.pop = 1'b0;
    bus.data_in = 6'h3F; step();
    bus.push = 1'b0;
    chk("ovf_error", 32'(bus.error), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd4);
    chk("ovf_valid", 32'(bus.valid_out), 32'd0);

    // Drain across the read-pointer wrap; 0x3F must not appear.
    bus.pop = 1'b1;
    step(); chk("wrap_d0", 32'(bus.data_out), 32'h0D);
    step(); chk("wrap_d1", 32'(bus.data_out), 32'h11);
    step(); chk("wrap_d2", 32'(bus.data_out), 32'h12);
    step(); chk("wrap_d3", 32'(bus.data_out), 32'h13);
    chk("wrap_empty", 32'(bus.empty), 32'd1);
    chk("wrap_error_sticky", 32'(bus.error), 32'd1);
    bus.pop = 1'b0;

    // Reset clears error, count and restores default thresholds.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_error", 32'(bus.error), 32'd0);
    chk("rst2_count", 32'(bus.count), 32'd0);
    chk("rst2_dout", 32'(bus.data_out), 32'd0);
    bus.push = 1'b1;
    bus.data_in = 6'h21; step();
    bus.data_in = 6'h22; step();
    bus.data_in = 6'h23; step();
    bus.push = 1'b0;
    chk("rst2_af_default", 32'(bus.almost_full), 32'd1);
    bus.pop = 1'b1;
    step(); step(); step();
    bus.pop = 1'b0;
    chk("rst2_drain_data", 32'(bus.data_out), 32'h23);
    chk("rst2_drain_empty", 32'(bus.empty), 32'd1);
    chk("rst2_error_clean", 32'(bus.error), 32'd0);

    // Underflow with simultaneous push.
    bus.pop = 1'b1; bus.push = 1'b1; bus.data_in = 6'h15;
    step();
    bus.push = 1'b0;
    chk("udf_valid", 32'(bus.valid_out), 32'd0);
    chk("udf_error", 32'(bus.error), 32'd1);
    chk("udf_count", 32'(bus.count), 32'd1);
    step();
    bus.pop = 1'b0;
    chk("udf_next_data", 32'(bus.data_out), 32'h15);
    chk("udf_next_valid", 32'(bus.valid_out), 32'd1);
    chk("udf_next_count", 32'(bus.count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
